stack_op_sequencer: RTL and testbench

//  Initiator side of the operand-stack push/pop protocol (trigger/push/write_value/read_value/done).

---
 rtl/stack_seq_pkg.sv | 63 ++++++
 rtl/stack_seq_alu.sv | 40 ++++
 rtl/stack_op_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the operand-stack command sequencer.
// Contents: opcode enum, FSM state enum, opcode classification helpers.
// Optional feature macro: STACK_SEQ_DUPSWAP_EN (enables DUP and SWAP opcodes).
package stack_seq_pkg;

  localparam int unsigned OP_BITS = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_USHR = 4'h8,
    OP_NEG  = 4'h9,
    OP_DUP  = 4'hA,
    OP_SWAP = 4'hB,
    OP_POP  = 4'hC
  } op_e;

  // PUSH2_* are only reachable when the DUP/SWAP feature is built in.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_POPB_REQ   = 4'd1,
    S_POPB_WAIT  = 4'd2,
    S_POPA_REQ   = 4'd3,
    S_POPA_WAIT  = 4'd4,
    S_EXEC       = 4'd5,
    S_PUSH_REQ   = 4'd6,
    S_PUSH_WAIT  = 4'd7,
    S_PUSH2_REQ  = 4'd8,
    S_PUSH2_WAIT = 4'd9,
    S_RESP       = 4'd10
  } state_e;

  // Opcodes that consume a single operand (no second pop).
  function automatic logic is_unary(input op_e op);
    logic u;
    case (op)
      OP_NEG, OP_POP, OP_DUP: u = 1'b1;
      default:                u = 1'b0;
    endcase
    return u;
  endfunction

  // Raw opcode bits are classified so that undefined encodings fall out as illegal.
  function automatic logic is_legal(input logic [OP_BITS-1:0] op);
    logic l;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC: l = 1'b1;
`ifdef STACK_SEQ_DUPSWAP_EN
      4'hA, 4'hB:                          l = 1'b1;
`endif
      default:                             l = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational datapath for the stack sequencer.
// Ports: a (second pop), b (first pop / top of stack), op (latched opcode),
//        result = a op b, or the first value to push for DUP/SWAP.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [4:0] shamt_s;
  assign shamt_s = b[4:0];

  // Result selection; everything wraps modulo 2^WIDTH.
  always_comb begin
    result = ZERO_W;
    case (op)
      OP_ADD:           result = a + b;
      OP_SUB:           result = a - b;
      OP_MUL:           result = a * b;
      OP_AND:           result = a & b;
      OP_OR:            result = a | b;
      OP_XOR:           result = a ^ b;
      OP_SHL:           result = a << shamt_s;
      OP_SHR:           result = WIDTH'($signed(a) >>> shamt_s);
      OP_USHR:          result = a >> shamt_s;
      OP_NEG:           result = ZERO_W - b;
      // DUP and SWAP both push the old top first.
      OP_DUP, OP_SWAP:  result = b;
      default:          result = ZERO_W;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Initiator side of the operand-stack trigger/push/done protocol. Accepts one
// stack-arithmetic command, pops operands (b first, then a), computes a op b,
// pushes the result and pulses rsp_valid.
// Ports: clk, rst (sync, active high); cmd_valid/cmd_ready/cmd_op command side;
//        rsp_valid/rsp_result/rsp_err response pulses; stk_trigger/stk_push/
//        stk_write_value/stk_read_value/stk_done stack side.
// Optional feature macro: STACK_SEQ_DUPSWAP_EN adds DUP (A) and SWAP (B),
// which need a second push (PUSH2_REQ/PUSH2_WAIT).
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             stk_trigger,
  output logic             stk_push,
  output logic [WIDTH-1:0] stk_write_value,
  input  logic [WIDTH-1:0] stk_read_value,
  input  logic             stk_done
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             trig_q, trig_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] wv_q, wv_d;
  logic [WIDTH-1:0] alu_result_s;

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result_s)
  );

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_result      = rsp_result_q;
  assign stk_trigger     = trig_q;
  assign stk_push        = push_q;
  assign stk_write_value = wv_q;

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that every *_REQ state is exactly the cycle in which trig_q is high.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_result_d = ZERO_W;
    trig_d       = 1'b0;
    push_d       = push_q;
    wv_d         = wv_q;
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (is_legal(cmd_op)) begin
            op_d    = op_e'(cmd_op);
            state_d = S_POPB_REQ;
            trig_d  = 1'b1;
            push_d  = 1'b0;
          end else begin
            // Illegal opcode: respond next cycle without touching the stack.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POPB_REQ: state_d = S_POPB_WAIT;
      S_POPB_WAIT: begin
        if (stk_done) begin
          b_d = stk_read_value;
          if (op_q == OP_POP) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else if (is_unary(op_q)) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_POPA_REQ;
            trig_d  = 1'b1;
          end
        end else begin
          state_d = S_POPB_WAIT;
        end
      end
      S_POPA_REQ: state_d = S_POPA_WAIT;
      S_POPA_WAIT: begin
        if (stk_done) begin
          a_d     = stk_read_value;
          state_d = S_EXEC;
        end else begin
          state_d = S_POPA_WAIT;
        end
      end
      S_EXEC: begin
        state_d = S_PUSH_REQ;
        trig_d  = 1'b1;
        push_d  = 1'b1;
        wv_d    = alu_result_s;
      end
      S_PUSH_REQ: state_d = S_PUSH_WAIT;
      S_PUSH_WAIT: begin
        if (stk_done) begin
`ifdef STACK_SEQ_DUPSWAP_EN
          if ((op_q == OP_DUP) || (op_q == OP_SWAP)) begin
            state_d = S_PUSH2_REQ;
            trig_d  = 1'b1;
            if (op_q == OP_SWAP) begin
              wv_d = a_q;
            end else begin
              wv_d = b_q;
            end
          end else begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = wv_q;
            push_d       = 1'b0;
            wv_d         = ZERO_W;
          end
`else
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = wv_q;
          push_d       = 1'b0;
          wv_d         = ZERO_W;
`endif
        end else begin
          state_d = S_PUSH_WAIT;
        end
      end
`ifdef STACK_SEQ_DUPSWAP_EN
      S_PUSH2_REQ: state_d = S_PUSH2_WAIT;
      S_PUSH2_WAIT: begin
        if (stk_done) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = wv_q;
          push_d       = 1'b0;
          wv_d         = ZERO_W;
        end else begin
          state_d = S_PUSH2_WAIT;
        end
      end
`endif
      S_RESP: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        push_d      = 1'b0;
        wv_d        = ZERO_W;
      end
    endcase
  end

  // State, operand latches and registered protocol outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      a_q          <= ZERO_W;
      b_q          <= ZERO_W;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= ZERO_W;
      trig_q       <= 1'b0;
      push_q       <= 1'b0;
      wv_q         <= ZERO_W;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
      trig_q       <= trig_d;
      push_q       <= push_d;
      wv_q         <= wv_d;
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer: a bench-owned stack memory with a
// random-latency responder, and a reference model working on a queue.
module tb_stack_op_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        stk_trigger;
  logic        stk_push;
  logic [31:0] stk_write_value;
  logic [31:0] stk_read_value;
  logic        stk_done;

  stack_op_sequencer #(.WIDTH(32), .OPW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_err         (rsp_err),
    .stk_trigger     (stk_trigger),
    .stk_push        (stk_push),
    .stk_write_value (stk_write_value),
    .stk_read_value  (stk_read_value),
    .stk_done        (stk_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem[$];
  logic [31:0] exp_mem[$];

  bit          busy;
  int          cnt;
  bit          rec_push;
  logic [31:0] rec_val;
  int          trig_count;
  int          first_trig_cyc;
  int          last_done_cyc;
  bit          prev_trig;
  bit          inject_spur;
  logic [31:0] spur_val;
  int          force_lat;
  int          acc_cyc;
  int          rsp_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Stack responder: services one request at a time and checks the protocol.
  initial begin
    stk_done = 1'b0; stk_read_value = 32'h0; busy = 1'b0; prev_trig = 1'b0;
    trig_count = 0; first_trig_cyc = -1; last_done_cyc = -1;
    inject_spur = 1'b0; spur_val = 32'h0; force_lat = 0;
    forever begin
      @(negedge clk);
      stk_done = 1'b0;
      stk_read_value = 32'h0;
      if (rst) begin
        busy = 1'b0;
        prev_trig = 1'b0;
      end else begin
        if (stk_trigger) begin
          checks++;
          if (prev_trig) begin
            errors++;
            $display("FAIL trig_width: trigger high for 2+ cycles at cyc %0d (required 1 cycle)", cyc);
          end
          checks++;
          if (busy) begin
            errors++;
            $display("FAIL outstanding: trigger at cyc %0d while a request is pending (required none)", cyc);
          end
          if (first_trig_cyc < 0) first_trig_cyc = cyc;
          trig_count++;
          busy = 1'b1;
          rec_push = stk_push;
          rec_val = stk_write_value;
          cnt = (force_lat != 0) ? force_lat : int'($urandom_range(1, 12));
        end else if (busy) begin
          checks++;
          if (stk_push !== rec_push || stk_write_value !== rec_val) begin
            errors++;
            $display("FAIL hold: push=%0b data=%h at cyc %0d, required push=%0b data=%h",
                     stk_push, stk_write_value, cyc, rec_push, rec_val);
          end
          cnt--;
          if (cnt <= 0) begin
            stk_done = 1'b1;
            busy = 1'b0;
            last_done_cyc = cyc;
            if (rec_push) mem.push_back(rec_val);
            else if (mem.size() > 0) stk_read_value = mem.pop_back();
            else stk_read_value = 32'h0;
          end
        end else if (inject_spur) begin
          stk_done = 1'b1;
          stk_read_value = spur_val;
          inject_spur = 1'b0;
        end
        prev_trig = stk_trigger;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    logic [31:0] fill;
    sh = b % 32;
    ones = 32'hFFFF_FFFF;
    fill = (a >= 32'h8000_0000) ? ~(ones >> sh) : 32'h0;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return a << sh;
      4'd7: return (a >> sh) | fill;
      4'd8: return a >> sh;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_mem.size() > 0) return exp_mem.pop_back();
    return 32'h0;
  endfunction

  // Applies one command to exp_mem; nops is the expected number of stack requests.
  task automatic model_exec(input logic [3:0] op, output logic [31:0] res, output logic err, output int nops);
    logic [31:0] a;
    logic [31:0] b;
    err = 1'b0; res = 32'h0; nops = 0;
    if (op <= 4'd8) begin
      b = pop_exp(); a = pop_exp();
      res = calc(op, a, b); exp_mem.push_back(res); nops = 3;
    end else if (op == 4'd9) begin
      b = pop_exp(); res = 32'h0 - b; exp_mem.push_back(res); nops = 2;
    end else if (op == 4'hC) begin
      b = pop_exp(); nops = 1;
`ifdef STACK_SEQ_DUPSWAP_EN
    end else if (op == 4'hA) begin
      b = pop_exp(); exp_mem.push_back(b); exp_mem.push_back(b); res = b; nops = 3;
    end else if (op == 4'hB) begin
      b = pop_exp(); a = pop_exp(); exp_mem.push_back(b); exp_mem.push_back(a); res = a; nops = 4;
`endif
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic cmp_mem(input string name);
    int bad;
    bad = -1;
    checks++;
    if (mem.size() != exp_mem.size()) begin
      errors++;
      $display("FAIL %s_stack: depth %0d, required %0d", name, mem.size(), exp_mem.size());
    end else begin
      foreach (mem[i]) if (bad < 0 && mem[i] !== exp_mem[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_stack: entry %0d = %h, required %h", name, bad, mem[bad], exp_mem[bad]);
      end
    end
  endtask

  // Issues one command from an idle negedge and returns at the idle negedge after the response.
  task automatic run_cmd(input logic [3:0] op, output logic [31:0] res, output logic err, output bit ok);
    int n;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_cmd: cmd_ready=%0b, required 1", cmd_ready);
    end
    trig_count = 0; first_trig_cyc = -1;
    cmd_valid = 1'b1; cmd_op = op; acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 4'($urandom);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (rsp_valid === 1'b1);
    res = rsp_result; err = rsp_err; rsp_cyc = cyc;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_rsp: rsp_valid=%0b cmd_ready=%0b, required 0 and 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic exec_check(input logic [3:0] op, input string name);
    logic [31:0] exp_res, got_res;
    logic        exp_err, got_err;
    int          nops;
    bit          ok;
    exp_mem = mem;
    model_exec(op, exp_res, exp_err, nops);
    run_cmd(op, got_res, got_err, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no rsp_valid within 300 cycles (op %h)", name, op);
    end else begin
      checks++;
      if (got_err !== exp_err) begin
        errors++;
        $display("FAIL %s_err: op %h rsp_err=%0b, required %0b", name, op, got_err, exp_err);
      end
      checks++;
      if (got_res !== exp_res) begin
        errors++;
        $display("FAIL %s_result: op %h rsp_result=%h, required %h", name, op, got_res, exp_res);
      end
      checks++;
      if (trig_count != nops) begin
        errors++;
        $display("FAIL %s_requests: op %h %0d triggers, required %0d", name, op, trig_count, nops);
      end
      checks++;
      if (exp_err ? (rsp_cyc != acc_cyc + 1)
                  : (first_trig_cyc != acc_cyc + 1 || rsp_cyc != last_done_cyc + 1)) begin
        errors++;
        $display("FAIL %s_latency: op %h accept %0d trig %0d done %0d rsp %0d", name, op,
                 acc_cyc, first_trig_cyc, last_done_cyc, rsp_cyc);
      end
      cmp_mem(name);
    end
  endtask

  task automatic set_stack2(input logic [31:0] a, input logic [31:0] b);
    mem.delete();
    mem.push_back(32'h1111_1111);
    mem.push_back(a);
    mem.push_back(b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, stk_trigger, stk_push} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err/trig/push=%b, required 10000",
               {cmd_ready, rsp_valid, rsp_err, stk_trigger, stk_push});
    end
    checks++;
    if (rsp_result !== 32'h0 || stk_write_value !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rsp_result=%h write_value=%h, required 0", rsp_result, stk_write_value);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    set_stack2(32'd7, 32'd5);            exec_check(4'd0, "add");
    set_stack2(32'd10, 32'd3);           exec_check(4'd1, "sub_order");
    set_stack2(32'h8000_0000, 32'd33);   exec_check(4'd8, "ushr_mod32");
    set_stack2(32'hFFFF_FFFF, 32'd1);    exec_check(4'd0, "add_wrap");
    set_stack2(32'h8000_0000, 32'd1);    exec_check(4'd7, "shr_arith");
    set_stack2(32'd6, 32'd4);            exec_check(4'd9, "neg");
    set_stack2(32'd6, 32'd4);            exec_check(4'hC, "pop");
  endtask

  task automatic test_illegal();
    set_stack2(32'd1, 32'd2);
    exec_check(4'hF, "illegal_f");
    exec_check(4'hD, "illegal_d");
`ifndef STACK_SEQ_DUPSWAP_EN
    exec_check(4'hA, "illegal_dup");
    exec_check(4'hB, "illegal_swap");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      while (mem.size() < 4) mem.push_back($urandom);
      exec_check(4'($urandom_range(0, 15)), "random");
    end
  endtask

  // cmd_valid stays high throughout; opcode noise while busy must be ignored.
  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    logic        e1, e2;
    int          n1, n2, n;
    set_stack2(32'd20, 32'd8);
    mem.push_back(32'd3);
    exp_mem = mem;
    model_exec(4'd0, r1, e1, n1);
    model_exec(4'd1, r2, e2, n2);
    trig_count = 0; first_trig_cyc = -1;
    cmd_valid = 1'b1; cmd_op = 4'd0;
    @(negedge clk);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      cmd_op = 4'($urandom);
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== r1) begin
      errors++;
      $display("FAIL b2b_first: valid=%0b result=%h, required 1 and %h", rsp_valid, rsp_result, r1);
    end
    cmd_op = 4'd1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== r2 || trig_count != n1 + n2) begin
      errors++;
      $display("FAIL b2b_second: valid=%0b result=%h triggers=%0d, required 1, %h, %0d",
               rsp_valid, rsp_result, trig_count, r2, n1 + n2);
    end
    @(negedge clk);
    cmp_mem("b2b");
  endtask

  task automatic test_spurious();
    bit seen_rsp;
    trig_count = 0; seen_rsp = 1'b0;
    spur_val = $urandom; inject_spur = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    checks++;
    if (seen_rsp || trig_count != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_done: rsp=%0b triggers=%0d ready=%0b, required 0 0 1",
               seen_rsp, trig_count, cmd_ready);
    end
    set_stack2(32'd9, 32'd4);
    exec_check(4'd5, "after_spurious");
  endtask

  task automatic test_reset_mid();
    int n;
    set_stack2(32'd100, 32'd50);
    exp_mem = mem;
    void'(pop_exp());
    force_lat = 3; trig_count = 0; first_trig_cyc = -1;
    cmd_valid = 1'b1; cmd_op = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (trig_count < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (trig_count < 2) begin
      errors++;
      $display("FAIL reset_mid_reach: %0d triggers, required 2", trig_count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, stk_trigger, stk_push, rsp_result, stk_write_value} !== {1'b1, 68'h0}) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%0b valid=%0b err=%0b trig=%0b push=%0b res=%h wv=%h, required 1 and zeros",
               cmd_ready, rsp_valid, rsp_err, stk_trigger, stk_push, rsp_result, stk_write_value);
    end
    rst = 1'b0; force_lat = 0;
    @(negedge clk);
    cmp_mem("reset_mid");
    exec_check(4'd2, "after_reset");
  endtask

`ifdef STACK_SEQ_DUPSWAP_EN
  task automatic test_dupswap();
    set_stack2(32'd1, 32'd2);
    exec_check(4'hB, "swap");
    set_stack2(32'd5, 32'd9);
    exec_check(4'hA, "dup");
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_illegal();
    test_random();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
`ifdef STACK_SEQ_DUPSWAP_EN
    test_dupswap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
